cell_evaluator: RTL and testbench
=================================

Name: cell_evaluator

Overview:
Computes the next-generation value of one arena cell under Conway B3/S23 rules. It accepts a cell coordinate from the generation sequencer and issues nine sequential reads through the cell reader: the 3x3 neighbourhood, including the cell itself. It counts the live neighbours and returns the next value with a one-cycle done pulse. It sits directly upstream of the cell reader and drives its start/column/row inputs.

Parameters:
ARENA_WIDTH, 10, number of columns (1..256)
ARENA_HEIGHT, 10, number of rows (1..256)
WRAP, 1, 1 = toroidal arena (edges wrap); 0 = cells outside the arena read as dead, and no read is issued for them

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low (0 = reset)
start  input  1  request evaluation of (cell_column, cell_row); accepted only when ready=1
ready  output  1  idle and able to accept start
cell_column  input  8  column of target cell, sampled on accepted start
cell_row  input  8  row of target cell, sampled on accepted start
done  output  1  one-cycle pulse; next_value and live_count valid
next_value  output  1  next-generation state of target cell; held until the next done
live_count  output  4  live neighbours, excluding self (0..8); held with next_value
rd_start  output  1  read request to cell reader
rd_ready  input  1  reader ready; a read completes on an edge where rd_start & rd_ready
rd_column  output  8  read column; 0 when rd_start=0
rd_row  output  8  read row; 0 when rd_start=0
rd_value  input  1  read data, valid combinationally while rd_start & rd_ready

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; ready=1, done=0, next_value=0, live_count=0, rd_start=0, internal index/count/self cleared.
- FSM states: IDLE -> SCAN -> DONE -> IDLE.
- IDLE: ready=1.
  - start=1 with cell_column<ARENA_WIDTH and cell_row<ARENA_HEIGHT: capture the coordinate, clear the count, set index=0, go to SCAN.
  - Out-of-range start: ignored; stay IDLE, no done.
- SCAN: ready=0; index 0..8 in row-major order, offset (dr,dc) = (index/3-1, index%3-1); index 4 is self.
  - Neighbour coordinate: col+dc, row+dr.
  - WRAP=1: -1 maps to dim-1 and dim maps to 0.
  - WRAP=0: an out-of-range neighbour is skipped in one cycle with rd_start=0 and counts as dead.
  - In-range read: rd_start=1 with rd_column/rd_row driven.
  - On an edge with rd_start & rd_ready: index 4 latches self=rd_value; any other index adds rd_value to the count. Index then advances.
  - rd_ready=0 stalls: rd_start and the coordinate are held and the index does not advance.
  - After index 8 completes, go to DONE.
- DONE (one cycle): done=1. live_count and next_value register on entry (next_value = count==3 | (self & count==2)). Next state IDLE; ready returns to 1 in the following cycle.
- Latency with rd_ready always 1: start accepted at edge 0, reads on edges 1..9, done=1 during cycle 10, ready=1 in cycle 11.
- start while ready=0: ignored, never queued.
- Dimension 1 with WRAP=1: a neighbour may alias the cell itself and is read and counted as a neighbour (legal, deterministic).
- Count arithmetic: 4-bit, saturation impossible (max 8).
- Reset mid-SCAN: abort immediately to the reset values; no done is produced for the aborted request.

Decomposition:
- Shared package life_pkg:
  - state encoding (IDLE/SCAN/DONE)
  - NEIGH_DR/NEIGH_DC offset tables for index 0..8
  - SELF_INDEX=4
  - BIRTH_COUNT=3, SURVIVE_COUNT=2
- One natural sub-module: coord_wrap. Combinational; given coordinate, signed offset, dimension and WRAP, it returns the neighbour coordinate and an in_range flag. It is instantiated twice, once for column and once for row.

Test Plan:
- Blinker: arena 10x10, live cells (4,5),(5,5),(6,5), rd_ready=1; evaluate (5,4) -> done at cycle 10, live_count=3, next_value=1. Evaluate (4,5) -> live_count=1, next_value=0. Evaluate (5,5) -> live_count=2, next_value=1.
- Corner wrap: WRAP=1, live cells (9,9),(0,9),(9,0), target (0,0) dead -> reads include column 9/row 9, live_count=3, next_value=1. Same arena with WRAP=0 -> live_count=0, next_value=0, and rd_start is never asserted with column or row 9.
- Stall: rd_ready low for 3 cycles at index 2 -> rd_column/rd_row held constant, no count change, done delayed exactly 3 cycles to cycle 13.
- Busy/invalid start: start pulsed during SCAN -> ignored, single done. start with cell_column=10 in a 10-wide arena -> ready stays 1, no rd_start, no done.
- Reset mid-scan: assert reset=0 at index 5 -> ready=1, rd_start=0, done=0 immediately. A following valid start produces a correct result with count not polluted by the aborted scan.
- Full neighbourhood: all nine cells live -> live_count=8, next_value=0. Only self live -> live_count=0, next_value=0.

Source files
------------

// File: rtl/cell_evaluator_pkg.sv
// Shared definitions for the Life cell evaluator: FSM encoding, neighbourhood
// offset tables and B3/S23 rule constants.
package life_pkg;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    // Row-major 3x3 scan; entry i gives the (dr, dc) offset of neighbour i.
    localparam logic signed [1:0] NEIGH_DR [9] = '{-2'sd1, -2'sd1, -2'sd1,
                                                   2'sd0,  2'sd0,  2'sd0,
                                                   2'sd1,  2'sd1,  2'sd1};
    localparam logic signed [1:0] NEIGH_DC [9] = '{-2'sd1, 2'sd0, 2'sd1,
                                                   -2'sd1, 2'sd0, 2'sd1,
                                                   -2'sd1, 2'sd0, 2'sd1};

    localparam logic [3:0] SELF_INDEX    = 4'd4;
    localparam logic [3:0] LAST_INDEX    = 4'd8;
    localparam logic [3:0] BIRTH_COUNT   = 4'd3;
    localparam logic [3:0] SURVIVE_COUNT = 4'd2;

endpackage

// File: rtl/cell_evaluator_if.sv
// Request/response and cell-reader signals of the cell evaluator.
// slave is the evaluator's view; master is the sequencer/reader side.
interface cell_evaluator_if;
    logic       start;
    logic       ready;
    logic [7:0] cell_column;
    logic [7:0] cell_row;
    logic       done;
    logic       next_value;
    logic [3:0] live_count;
    logic       rd_start;
    logic       rd_ready;
    logic [7:0] rd_column;
    logic [7:0] rd_row;
    logic       rd_value;

    modport slave (
        input  start, cell_column, cell_row, rd_ready, rd_value,
        output ready, done, next_value, live_count, rd_start, rd_column, rd_row
    );

    modport master (
        output start, cell_column, cell_row, rd_ready, rd_value,
        input  ready, done, next_value, live_count, rd_start, rd_column, rd_row
    );
endinterface

// File: rtl/cell_evaluator_coord_wrap.sv
// Neighbour coordinate along one axis: applies a -1/0/+1 offset, then either
// wraps toroidally or flags the result as outside the arena.
module coord_wrap #(
    parameter int unsigned DIM  = 10,
    parameter bit          WRAP = 1'b1
) (
    input  logic [7:0]        i_coord,
    input  logic signed [1:0] i_offset,
    output logic [7:0]        o_coord,
    output logic              o_in_range
);
    localparam logic [9:0] DIM_W   = 10'(DIM);
    localparam logic [7:0] DIM_MAX = 8'(DIM - 1);

    logic [9:0] w_sum;

    // Bit 9 set means the sum went negative (coord 0, offset -1).
    assign w_sum = {2'b00, i_coord} + {{8{i_offset[1]}}, i_offset};

    always_comb begin
        o_coord    = w_sum[7:0];
        o_in_range = 1'b1;
        if (w_sum[9]) begin
            o_coord    = DIM_MAX;
            o_in_range = WRAP;
        end else if (w_sum >= DIM_W) begin
            o_coord    = '0;
            o_in_range = WRAP;
        end
    end
endmodule

// File: rtl/cell_evaluator.sv
// Evaluates the next Life (B3/S23) state of one cell by reading its 3x3
// neighbourhood through the cell reader, one read per accepted handshake.
module cell_evaluator
    import life_pkg::*;
#(
    parameter int unsigned ARENA_WIDTH  = 10,
    parameter int unsigned ARENA_HEIGHT = 10,
    parameter bit          WRAP         = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    cell_evaluator_if.slave bus
);
    state_e     r_state;
    logic [3:0] r_index;
    logic [3:0] r_count;
    logic       r_self;
    logic [7:0] r_col;
    logic [7:0] r_row;
    logic       r_done;
    logic       r_next_value;
    logic [3:0] r_live_count;

    logic [7:0] w_nb_col;
    logic [7:0] w_nb_row;
    logic       w_col_ok;
    logic       w_row_ok;
    logic       w_rd_req;
    logic       w_rd_fire;
    logic       w_advance;
    logic       w_start_ok;
    logic [3:0] w_count_next;
    logic       w_self_next;

    coord_wrap #(.DIM(ARENA_WIDTH), .WRAP(WRAP)) u_wrap_col (
        .i_coord    (r_col),
        .i_offset   (NEIGH_DC[r_index]),
        .o_coord    (w_nb_col),
        .o_in_range (w_col_ok)
    );

    coord_wrap #(.DIM(ARENA_HEIGHT), .WRAP(WRAP)) u_wrap_row (
        .i_coord    (r_row),
        .i_offset   (NEIGH_DR[r_index]),
        .o_coord    (w_nb_row),
        .o_in_range (w_row_ok)
    );

    assign w_rd_req  = (r_state == StScan) & w_col_ok & w_row_ok;
    assign w_rd_fire = w_rd_req & bus.rd_ready;
    // Off-arena neighbours (no wrap) are skipped without a read and count as dead.
    assign w_advance = (r_state == StScan) & (w_rd_fire | ~(w_col_ok & w_row_ok));

    assign w_count_next = r_count +
                          {3'b000, w_rd_fire & bus.rd_value & (r_index != SELF_INDEX)};
    assign w_self_next  = (w_rd_fire && r_index == SELF_INDEX) ? bus.rd_value : r_self;

    assign w_start_ok = bus.start
                      & ({1'b0, bus.cell_column} < 9'(ARENA_WIDTH))
                      & ({1'b0, bus.cell_row} < 9'(ARENA_HEIGHT));

    assign bus.ready      = (r_state == StIdle);
    assign bus.done       = r_done;
    assign bus.next_value = r_next_value;
    assign bus.live_count = r_live_count;
    assign bus.rd_start   = w_rd_req;
    assign bus.rd_column  = w_rd_req ? w_nb_col : '0;
    assign bus.rd_row     = w_rd_req ? w_nb_row : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_index      <= '0;
            r_count      <= '0;
            r_self       <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_done       <= 1'b0;
            r_next_value <= 1'b0;
            r_live_count <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start_ok) begin
                        r_col   <= bus.cell_column;
                        r_row   <= bus.cell_row;
                        r_count <= '0;
                        r_self  <= 1'b0;
                        r_index <= '0;
                        r_state <= StScan;
                    end
                end
                StScan: begin
                    if (w_advance) begin
                        r_count <= w_count_next;
                        r_self  <= w_self_next;
                        if (r_index == LAST_INDEX) begin
                            r_state      <= StDone;
                            r_done       <= 1'b1;
                            r_live_count <= w_count_next;
                            r_next_value <= (w_count_next == BIRTH_COUNT) |
                                            (w_self_next & (w_count_next == SURVIVE_COUNT));
                        end else begin
                            r_index <= r_index + 4'd1;
                        end
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_evaluator.sv
// Scoreboard bench for cell_evaluator: a wrapping and a non-wrapping 10x10
// instance share one arena model acting as the cell reader.
module tb_cell_evaluator;

    typedef struct {
        int unsigned live;
        bit          nv;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic arena [16][16];

    int num_checks = 0;
    int num_errors = 0;
    int dones_w = 0, dones_n = 0;
    int pushes_w = 0, pushes_n = 0;
    int saw9_w = 0, bad9_n = 0;
    bit watch_w = 1'b0, watch_n = 1'b0;
    exp_t q_w[$];
    exp_t q_n[$];

    always #5 clk = ~clk;

    cell_evaluator_if ifw ();
    cell_evaluator_if ifn ();

    cell_evaluator #(.ARENA_WIDTH(10), .ARENA_HEIGHT(10), .WRAP(1'b1)) dut_w (
        .clk   (clk),
        .reset (reset_n),
        .bus   (ifw)
    );

    cell_evaluator #(.ARENA_WIDTH(10), .ARENA_HEIGHT(10), .WRAP(1'b0)) dut_n (
        .clk   (clk),
        .reset (reset_n),
        .bus   (ifn)
    );

    assign ifw.rd_value = ifw.rd_start & arena[ifw.rd_row[3:0]][ifw.rd_column[3:0]];
    assign ifn.rd_value = ifn.rd_start & arena[ifn.rd_row[3:0]][ifn.rd_column[3:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ifw.done === 1'b1) begin
            dones_w++;
            if (q_w.size() == 0) check_eq("unexpected_done_w", 1, 0);
            else begin
                e = q_w.pop_front();
                check_eq("live_count_w", 32'(ifw.live_count), e.live);
                check_eq("next_value_w", 32'(ifw.next_value), 32'(e.nv));
            end
        end
        if (ifn.done === 1'b1) begin
            dones_n++;
            if (q_n.size() == 0) check_eq("unexpected_done_n", 1, 0);
            else begin
                e = q_n.pop_front();
                check_eq("live_count_n", 32'(ifn.live_count), e.live);
                check_eq("next_value_n", 32'(ifn.next_value), 32'(e.nv));
            end
        end
        if (watch_w && ifw.rd_start && (ifw.rd_column == 8'd9 || ifw.rd_row == 8'd9)) saw9_w++;
        if (watch_n && ifn.rd_start && (ifn.rd_column == 8'd9 || ifn.rd_row == 8'd9)) bad9_n++;
    end

    function automatic logic get_done(input bit sel);
        return sel ? ifn.done : ifw.done;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? ifn.ready : ifw.ready;
    endfunction

    task automatic set_start(input bit sel, input logic v, input int c, input int r);
        if (sel) begin
            ifn.start = v; ifn.cell_column = 8'(c); ifn.cell_row = 8'(r);
        end else begin
            ifw.start = v; ifw.cell_column = 8'(c); ifw.cell_row = 8'(r);
        end
    endtask

    task automatic clear_arena();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) arena[r][c] = 1'b0;
    endtask

    task automatic set_blinker();
        clear_arena();
        arena[5][4] = 1'b1; arena[5][5] = 1'b1; arena[5][6] = 1'b1;
    endtask

    // mode 0 normal, 1 stall at index 2, 2 start pulsed while busy, 3 reset at index 5
    task automatic eval(input bit sel, input int c, input int r, input int exp_live,
                        input bit exp_nv, input int exp_edge, input int mode);
        exp_t e;
        int n;
        @(negedge clk);
        set_start(sel, 1'b1, c, r);
        if (mode != 3) begin
            e.live = exp_live; e.nv = exp_nv;
            if (sel) begin q_n.push_back(e); pushes_n++; end
            else begin q_w.push_back(e); pushes_w++; end
        end
        @(posedge clk); #1;
        set_start(sel, 1'b0, c, r);
        n = 0;
        while (get_done(sel) !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (mode == 1 && n == 2) ifw.rd_ready = 1'b0;
            if (mode == 1 && n >= 3 && n <= 5) begin
                check_eq("stall_rd_start", 32'(ifw.rd_start), 1);
                check_eq("stall_rd_column", 32'(ifw.rd_column), 32'(c + 1));
                check_eq("stall_rd_row", 32'(ifw.rd_row), 32'(r - 1));
                if (n == 5) ifw.rd_ready = 1'b1;
            end
            if (mode == 2 && n == 4) set_start(sel, 1'b1, 5, 4);
            if (mode == 2 && n == 5) set_start(sel, 1'b0, 5, 4);
            if (mode == 3 && n == 5) begin
                reset_n = 1'b0;
                #1;
                check_eq("abort_ready", 32'(ifw.ready), 1);
                check_eq("abort_rd_start", 32'(ifw.rd_start), 0);
                check_eq("abort_done", 32'(ifw.done), 0);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
        end
        if (n >= 60) check_eq("done_timeout", 0, 1);
        check_eq("done_edge", n, exp_edge);
        @(posedge clk); #1;
        check_eq("ready_after_done", 32'(get_ready(sel)), 1);
        check_eq("done_one_cycle", 32'(get_done(sel)), 0);
    endtask

    initial begin
        int d0;
        reset_n = 1'b0;
        ifw.start = 1'b0; ifw.cell_column = '0; ifw.cell_row = '0; ifw.rd_ready = 1'b1;
        ifn.start = 1'b0; ifn.cell_column = '0; ifn.cell_row = '0; ifn.rd_ready = 1'b1;
        clear_arena();
        #12;
        check_eq("rst_ready", 32'(ifw.ready), 1);
        check_eq("rst_done", 32'(ifw.done), 0);
        check_eq("rst_next_value", 32'(ifw.next_value), 0);
        check_eq("rst_live_count", 32'(ifw.live_count), 0);
        check_eq("rst_rd_start", 32'(ifw.rd_start), 0);
        check_eq("rst_rd_start_n", 32'(ifn.rd_start), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Blinker
        set_blinker();
        eval(1'b0, 5, 4, 3, 1'b1, 9, 0);
        eval(1'b0, 4, 5, 1, 1'b0, 9, 0);
        eval(1'b0, 5, 5, 2, 1'b1, 9, 0);

        // Corner wrap vs. no wrap
        clear_arena();
        arena[9][9] = 1'b1; arena[9][0] = 1'b1; arena[0][9] = 1'b1;
        watch_w = 1'b1;
        eval(1'b0, 0, 0, 3, 1'b1, 9, 0);
        watch_w = 1'b0;
        check_eq("wrap_reads_edge", 32'(saw9_w != 0), 1);
        watch_n = 1'b1;
        eval(1'b1, 0, 0, 0, 1'b0, 9, 0);
        watch_n = 1'b0;
        check_eq("nowrap_no_edge_read", bad9_n, 0);

        // Stall, then start while busy
        set_blinker();
        eval(1'b0, 5, 4, 3, 1'b1, 12, 1);
        d0 = dones_w;
        eval(1'b0, 5, 5, 2, 1'b1, 9, 2);
        repeat (15) @(negedge clk);
        check_eq("busy_single_done", dones_w - d0, 1);

        // Out-of-range start
        d0 = dones_w;
        @(negedge clk);
        set_start(1'b0, 1'b1, 10, 3);
        @(negedge clk);
        set_start(1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("oor_ready", 32'(ifw.ready), 1);
            check_eq("oor_rd_start", 32'(ifw.rd_start), 0);
        end
        check_eq("oor_no_done", dones_w - d0, 0);

        // Reset mid-scan, then a clean evaluation
        eval(1'b0, 5, 4, 0, 1'b0, 0, 3);
        eval(1'b0, 5, 4, 3, 1'b1, 9, 0);

        // Full neighbourhood, and a lone cell
        clear_arena();
        for (int r = 4; r <= 6; r++)
            for (int c = 4; c <= 6; c++) arena[r][c] = 1'b1;
        eval(1'b0, 5, 5, 8, 1'b0, 9, 0);
        clear_arena();
        arena[5][5] = 1'b1;
        eval(1'b0, 5, 5, 0, 1'b0, 9, 0);

        repeat (4) @(negedge clk);
        check_eq("dones_w_total", dones_w, pushes_w);
        check_eq("dones_n_total", dones_n, pushes_n);
        check_eq("queue_w_empty", q_w.size(), 0);
        check_eq("queue_n_empty", q_n.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
